// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide controller.
package md_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } md_state_e;

  // |x| for a signed operand. An unsigned operand passes through unchanged.
  // |0x80000000| is 0x80000000, read as unsigned.
  function automatic logic [31:0] md_abs(input logic [31:0] x, input logic sgn);
    return (sgn & x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/md_divcore.sv
// Iterative unsigned core: restoring radix-2 divider, plus the shift-add multiplier
// in the default build (MD_FAST_MUL_EN undefined). One iteration per clock, MD_ITER iterations.
module md_divcore
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
`ifndef MD_FAST_MUL_EN
  input  logic        mul,
`endif
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
`ifndef MD_FAST_MUL_EN
  output logic [63:0] product,
`endif
  output logic        done
);

  logic                running;
  logic [MD_CNT_W-1:0] cnt;
  logic [31:0]         acc_hi;
  logic [31:0]         acc_lo;
  logic [31:0]         opnd;
  logic [31:0]         hi_nxt;
  logic [31:0]         lo_nxt;
  logic [32:0]         shifted;
  logic [33:0]         diff;
`ifndef MD_FAST_MUL_EN
  logic                is_mul;
  logic [32:0]         sum;
`endif

  // Divide: acc_hi is the partial remainder and acc_lo shifts dividend bits out and quotient bits in.
  // Multiply: {acc_hi, acc_lo} is the product/multiplier shift register.
  always_comb begin
    shifted = {acc_hi, acc_lo[31]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    hi_nxt  = diff[33] ? shifted[31:0] : diff[31:0];
    lo_nxt  = {acc_lo[30:0], ~diff[33]};
`ifndef MD_FAST_MUL_EN
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    if (is_mul) begin
      hi_nxt = sum[32:1];
      lo_nxt = {sum[0], acc_lo[31:1]};
    end
`endif
  end

  assign done      = running & (cnt == MD_CNT_W'(MD_ITER - 1));
  assign quotient  = acc_lo;
  assign remainder = acc_hi;
`ifndef MD_FAST_MUL_EN
  assign product   = {acc_hi, acc_lo};
`endif

  // NOTE: every register here takes <= so each iteration sees only pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
`ifndef MD_FAST_MUL_EN
      is_mul  <= 1'b0;
`endif
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc_hi  <= '0;
`ifndef MD_FAST_MUL_EN
      is_mul  <= mul;
      acc_lo  <= mul ? divisor : dividend;
      opnd    <= mul ? dividend : divisor;
`else
      acc_lo  <= dividend;
      opnd    <= divisor;
`endif
    end else if (running) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= cnt + MD_CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// MIPS-style HI/LO multiply/divide controller with pipeline stall.
// Optional MD_FAST_MUL_EN: single-cycle 32x32 multiply instead of the iterative one.
module md_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mult,
  input  logic        div,
  input  logic        mdsign,
  input  logic [1:0]  hilowen,
  input  logic [1:0]  hiloren,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic        busy
);

  md_state_e   state;
  md_state_e   state_nxt;
  logic        issue;
  logic        idle_issue;
  logic        mt_we;
  logic        neg_a;
  logic        neg_b;
  logic        op_div;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] prod_mag;
  logic [63:0] prod_s;
  logic        core_start;
  logic        core_done;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef MD_FAST_MUL_EN
  logic [31:0] op_a;
  logic [31:0] op_b;
`else
  logic [63:0] product;
`endif

  assign issue      = ex_valid & (mult | div) & ~flush;
  assign idle_issue = (state == IDLE) & issue;
  assign mt_we      = (state == IDLE) & ex_valid & (hilowen != 2'b11) & ~flush;
  assign mag_a      = md_abs(srca, mdsign);
  assign mag_b      = md_abs(srcb, mdsign);

`ifdef MD_FAST_MUL_EN
  assign core_start = idle_issue & ~mult;
`else
  assign core_start = idle_issue;
`endif

  md_divcore u_core (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (core_start),
`ifndef MD_FAST_MUL_EN
    .mul       (mult),
`endif
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quotient),
    .remainder (remainder),
`ifndef MD_FAST_MUL_EN
    .product   (product),
`endif
    .done      (core_done)
  );

  // NOTE: next state is defaulted before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue & mult)     state_nxt = MUL;
        else if (issue & div) state_nxt = DIV;
      end
`ifdef MD_FAST_MUL_EN
      MUL:     state_nxt = FIX;
`else
      MUL:     if (core_done) state_nxt = FIX;
`endif
      DIV:     if (core_done) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // DONE drops stall so the instruction retires while HI/LO are written.
  assign stall = ~flush & (idle_issue | ((state != IDLE) & (state != DONE)));
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sign fix-up on the unsigned magnitudes.
  always_comb begin
`ifdef MD_FAST_MUL_EN
    prod_mag = {32'd0, op_a} * {32'd0, op_b};
`else
    prod_mag = product;
`endif
    prod_s = (neg_a ^ neg_b) ? (~prod_mag + 64'd1) : prod_mag;
    if (op_div) begin
      fix_lo = (neg_a ^ neg_b) ? (~quotient + 32'd1) : quotient;
      fix_hi = neg_a ? (~remainder + 32'd1) : remainder;
    end else begin
      fix_lo = prod_s[31:0];
      fix_hi = prod_s[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      op_div <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
`ifdef MD_FAST_MUL_EN
      op_a   <= '0;
      op_b   <= '0;
`endif
    end else begin
      if (idle_issue) begin
        neg_a  <= mdsign & srca[31];
        neg_b  <= mdsign & srcb[31];
        op_div <= ~mult;
`ifdef MD_FAST_MUL_EN
        op_a   <= mag_a;
        op_b   <= mag_b;
`endif
      end
      if (state == FIX) begin
        res_hi <= fix_hi;
        res_lo <= fix_lo;
      end
      if (mt_we & hilowen[1]) hi <= srca;
      if (mt_we & hilowen[0]) lo <= srca;
      if ((state == DONE) & ~flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  // Registered read only: an mthi/mtlo in this cycle is visible next cycle.
  assign hilo_rdata = hiloren[1] ? hi : lo;

endmodule
